// File: rtl/nbcac_encoder_33_seq_if.sv
// Handshake bundle for the 33-wire NBCAC transmit encoder.
// master = producer/bus-driver side, slave = encoder.
interface nbcac_encoder_33_seq_if;
  logic [22:0] datain;
  logic        datain_valid;
  logic        datain_ready;
  logic [33:1] codeout;
  logic        codeout_valid;
  logic        codeout_ready;

  modport master (
    output datain, datain_valid, codeout_ready,
    input  datain_ready, codeout, codeout_valid
  );

  modport slave (
    input  datain, datain_valid, codeout_ready,
    output datain_ready, codeout, codeout_valid
  );
endinterface

// File: rtl/nbcac_encoder_33_seq.sv
// Iterative FNS greedy encoder: 23-bit word -> 33-wire NBCAC codeword,
// one codeword bit resolved per cycle, MSB (f_33) first.
module nbcac_encoder_33_seq (
  input  logic                         clock,
  input  logic                         rst,
  nbcac_encoder_33_seq_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  localparam logic [21:0] F33 = 22'd3524578;
  localparam logic [21:0] F32 = 22'd2178309;

  state_e      state_q, state_d;
  logic [22:0] r_q, r_d;
  logic [21:0] fa_q, fa_d, fb_q, fb_d;
  logic [5:0]  k_q, k_d;
  logic [33:1] code_q, code_d;
  logic        ge;

  assign ge = (r_q >= {1'b0, fa_q});

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      fa_q    <= '0;
      fb_q    <= '0;
      k_q     <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      k_q     <= k_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    k_d     = k_q;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        if (bus.datain_valid) begin
          r_d     = bus.datain;
          fa_d    = F33;
          fb_d    = F32;
          k_d     = 6'd33;
          code_d  = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // Bits shift in from the LSB, so after 33 steps d_33 lands at [33].
        code_d = {code_q[32:1], ge};
        if (ge) r_d = r_q - {1'b0, fa_q};
        fa_d = fb_q;
        fb_d = fa_q - fb_q;
        k_d  = k_q - 6'd1;
        if (k_q == 6'd1) state_d = DONE;
      end
      DONE: begin
        if (bus.codeout_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is masked by rst so it reads 0 throughout reset, not just after it.
  assign bus.datain_ready  = (state_q == IDLE) && !rst;
  assign bus.codeout_valid = (state_q == DONE);
  assign bus.codeout       = code_q;

endmodule

// File: tb/tb_nbcac_encoder_33_seq.sv
// Directed and stalled round-trip checks for the NBCAC 33-wire encoder.
module tb_nbcac_encoder_33_seq;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  nbcac_encoder_33_seq_if bus ();

  nbcac_encoder_33_seq dut (
    .clock (clk),
    .rst   (rst),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Receive-side decode: weighted sum of codeword bits.
  function automatic logic [63:0] fsum(input logic [32:0] c);
    logic [63:0] a, b, t, s;
    a = 64'd1; b = 64'd1; s = 64'd0;
    for (int k = 1; k <= 33; k++) begin
      if (c[k-1]) s = s + a;
      t = a + b;
      a = b;
      b = t;
    end
    return s;
  endfunction

  // Caller sits #1 after a rising edge.
  task automatic wait_valid(input string tag, output int cnt);
    cnt = 0;
    while (!bus.codeout_valid && cnt < 60) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, "_lat"}, 64'(cnt), 64'd33);
  endtask

  task automatic run_word(input string tag, input logic [22:0] w, input logic [32:0] exp);
    int cnt;
    chk({tag, "_rdy"}, 64'(bus.datain_ready), 64'd1);
    bus.datain       = w;
    bus.datain_valid = 1'b1;
    @(posedge clk); #1;
    bus.datain_valid = 1'b0;
    wait_valid(tag, cnt);
    chk({tag, "_code"}, 64'(bus.codeout), 64'(exp));
    bus.codeout_ready = 1'b1;
    @(posedge clk); #1;
    bus.codeout_ready = 1'b0;
    chk({tag, "_hs"}, 64'({bus.codeout_valid, bus.datain_ready}), 64'd1);
  endtask

  localparam int N_RND = 150;

  initial begin
    int          cnt;
    logic [32:0] held;
    logic [22:0] q[$];
    logic [22:0] cur, expw;
    logic [32:0] codev;
    logic        hs_in, hs_out;
    int          sent, got, cyc;

    rst = 1'b1;
    bus.datain = '0;
    bus.datain_valid = 1'b0;
    bus.codeout_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_rdy",  64'(bus.datain_ready), 64'd0);
    chk("rst_vld",  64'(bus.codeout_valid), 64'd0);
    chk("rst_code", 64'(bus.codeout), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_rdy", 64'(bus.datain_ready), 64'd1);
    chk("idle_vld", 64'(bus.codeout_valid), 64'd0);
    repeat (3) @(posedge clk); #1;
    chk("idle_vld2", 64'(bus.codeout_valid), 64'd0);

    // Small values and maximum
    run_word("v0",   23'd0,       33'h0_0000_0000);
    run_word("v1",   23'd1,       33'h0_0000_0002);
    run_word("v2",   23'd2,       33'h0_0000_0004);
    run_word("v3",   23'd3,       33'h0_0000_0008);
    run_word("v4",   23'd4,       33'h0_0000_000A);
    run_word("v100", 23'd100,     33'h0_0000_0428);
    run_word("vmax", 23'd8388607, 33'h1_EAA2_A904);

    // Backpressure in DONE with a pending input
    bus.datain = 23'd4;
    bus.datain_valid = 1'b1;
    @(posedge clk); #1;
    bus.datain_valid = 1'b0;
    wait_valid("bp", cnt);
    held = bus.codeout;
    chk("bp_code", 64'(held), 64'h0A);
    bus.datain = 23'd3;
    bus.datain_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", 64'({bus.codeout_valid, bus.datain_ready, bus.codeout}),
          64'({1'b1, 1'b0, held}));
    end
    bus.codeout_ready = 1'b1;
    @(posedge clk); #1;
    bus.codeout_ready = 1'b0;
    chk("bp_rel", 64'({bus.codeout_valid, bus.datain_ready}), 64'd1);
    @(posedge clk); #1;
    bus.datain_valid = 1'b0;
    chk("bp_acc", 64'(bus.datain_ready), 64'd0);
    wait_valid("bp2", cnt);
    chk("bp2_code", 64'(bus.codeout), 64'h08);
    bus.codeout_ready = 1'b1;
    @(posedge clk); #1;
    bus.codeout_ready = 1'b0;

    // Mid-flight reset during CALC
    bus.datain = 23'd5;
    bus.datain_valid = 1'b1;
    @(posedge clk); #1;
    bus.datain_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mrst_out", 64'({bus.datain_ready, bus.codeout_valid, bus.codeout}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mrst_idle", 64'({bus.datain_ready, bus.codeout_valid}), 64'h2);
    run_word("v7", 23'd7, 33'h0_0000_0014);

    // Random round-trip with stalls on both sides
    sent = 0; got = 0; cyc = 0;
    cur = 23'($urandom);
    while (got < N_RND && cyc < 30000) begin
      @(negedge clk);
      bus.datain        = cur;
      bus.datain_valid  = (sent < N_RND) && ($urandom_range(3) != 0);
      bus.codeout_ready = ($urandom_range(2) != 0);
      hs_in  = bus.datain_valid && bus.datain_ready;
      hs_out = bus.codeout_valid && bus.codeout_ready;
      codev  = bus.codeout;
      @(posedge clk);
      cyc++;
      if (hs_in) begin
        q.push_back(cur);
        sent++;
        cur = 23'($urandom);
      end
      if (hs_out) begin
        if (q.size() == 0) chk("rnd_dup", 64'd1, 64'd0);
        else begin
          expw = q.pop_front();
          chk("rnd_sum", fsum(codev), 64'(expw));
        end
        got++;
      end
    end
    #1;
    bus.datain_valid = 1'b0;
    bus.codeout_ready = 1'b0;
    chk("rnd_count", 64'(got), 64'(N_RND));
    chk("rnd_left", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
